// File: rtl/restador_serie.sv
// ---------------------------------------------------------------------------
// restador_serie
//   Bit-serial subtractor: D = A - B, one bit per clock, LSB first, through a
//   single full-subtractor cell and a borrow flip-flop.
//
//   Handshake: inicio is sampled only while idle (REPOSO). The accepting edge
//   captures A and B and raises ocupado. Exactly ANCHO edges later listo
//   pulses for one cycle, ocupado falls, and the result outputs update all
//   at once. inicio while ocupado=1 is ignored, not queued. inicio in the
//   listo cycle is accepted, because the FSM is already back in REPOSO.
//
//   Ports
//     clk             rising-edge clock
//     rst_n           asynchronous active-low reset
//     inicio          start request (sampled in REPOSO)
//     A, B            minuend / subtrahend (sampled on the accepting edge)
//     ocupado         operation in progress
//     listo           one-cycle result-valid pulse
//     diferencia      A - B modulo 2^ANCHO (held until next completion)
//     prestamo_salida final borrow, 1 iff A < B unsigned
//     desborde        two's-complement overflow of A - B
//
//   FSM state is held in 'estado' (REPOSO/RESTA) for checker binding.
// ---------------------------------------------------------------------------
module restador_serie #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic [ANCHO-1:0] A,
    input  logic [ANCHO-1:0] B,
    output logic             ocupado,
    output logic             listo,
    output logic [ANCHO-1:0] diferencia,
    output logic             prestamo_salida,
    output logic             desborde
);

    localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(ANCHO - 1);

    typedef enum logic {
        REPOSO = 1'b0,
        RESTA  = 1'b1
    } estado_t;

    estado_t estado;
    estado_t estado_sig;

    logic [ANCHO-1:0] reg_a;
    logic [ANCHO-1:0] reg_b;
    logic [ANCHO-1:0] reg_d;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             signo_a;
    logic             signo_b;

    // Full-subtractor cell on the current LSBs.
    logic a0;
    logic b0;
    logic d_bit;
    logic borrow_sig;
    logic ultimo_bit;

    assign a0         = reg_a[0];
    assign b0         = reg_b[0];
    assign d_bit      = a0 ^ b0 ^ borrow;
    assign borrow_sig = (~a0 & b0) | (~(a0 ^ b0) & borrow);
    assign ultimo_bit = (cnt == ULTIMO);

    // Next-state logic.
    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO: if (inicio) estado_sig = RESTA;
            RESTA:  if (ultimo_bit) estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a           <= '0;
            reg_b           <= '0;
            reg_d           <= '0;
            borrow          <= 1'b0;
            cnt             <= '0;
            signo_a         <= 1'b0;
            signo_b         <= 1'b0;
            ocupado         <= 1'b0;
            listo           <= 1'b0;
            diferencia      <= '0;
            prestamo_salida <= 1'b0;
            desborde        <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        reg_a   <= A;
                        reg_b   <= B;
                        reg_d   <= '0;
                        borrow  <= 1'b0;
                        cnt     <= '0;
                        signo_a <= A[ANCHO-1];
                        signo_b <= B[ANCHO-1];
                        ocupado <= 1'b1;
                    end
                end
                RESTA: begin
                    reg_a  <= reg_a >> 1;
                    reg_b  <= reg_b >> 1;
                    reg_d  <= {d_bit, reg_d[ANCHO-1:1]};
                    borrow <= borrow_sig;
                    cnt    <= cnt + CW'(1);
                    if (ultimo_bit) begin
                        // The MSB of the finished result is the bit being
                        // produced right now, so overflow is judged on d_bit.
                        diferencia      <= {d_bit, reg_d[ANCHO-1:1]};
                        prestamo_salida <= borrow_sig;
                        desborde        <= (signo_a != signo_b) && (d_bit != signo_a);
                        listo           <= 1'b1;
                        ocupado         <= 1'b0;
                        cnt             <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restador_serie.sv
// ---------------------------------------------------------------------------
// tb_restador_serie
//   Randomized plus directed bench for restador_serie (ANCHO = 8).
//   Reference model: integer arithmetic on A and B (unsigned difference,
//   unsigned compare for borrow, signed range test for overflow) and a
//   latency of ANCHO edges from the accepting edge to listo.
//   Handshake under test: inicio is taken on an edge only while the design is
//   idle; listo pulses exactly ANCHO edges after that edge; ocupado is high
//   from the accepting edge until the listo edge.
// ---------------------------------------------------------------------------
module tb_restador_serie;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         inicio;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ocupado;
    logic         listo;
    logic [W-1:0] diferencia;
    logic         prestamo_salida;
    logic         desborde;

    restador_serie #(.ANCHO(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inicio          (inicio),
        .A               (A),
        .B               (B),
        .ocupado         (ocupado),
        .listo           (listo),
        .diferencia      (diferencia),
        .prestamo_salida (prestamo_salida),
        .desborde        (desborde)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int             n_checks = 0;
    int             n_pass   = 0;
    int             cyc      = 0;
    // packed expectation: {prestamo, desborde, diferencia}
    logic [W+1:0]   exp_q[$];
    int             cyc_q[$];
    logic [W+1:0]   res_model = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model from plain arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint r;
        logic   ovf;
        logic   brw;
        logic [W-1:0] d;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = (ua >= (longint'(1) <<< (W - 1))) ? ua - (longint'(1) <<< W) : ua;
        sb  = (ub >= (longint'(1) <<< (W - 1))) ? ub - (longint'(1) <<< W) : ub;
        r   = sa - sb;
        ovf = (r > ((longint'(1) <<< (W - 1)) - 1)) || (r < -(longint'(1) <<< (W - 1)));
        brw = (ua < ub);
        d   = W'(ua - ub);
        return {brw, ovf, d};
    endfunction

    // ---------------- monitor ----------------
    // Samples 2 time units after every rising edge.
    initial begin
        logic [W+1:0] e;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #2;
            if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
                check("listo_due", 64'(listo), 64'(1));
                e = exp_q.pop_front();
                void'(cyc_q.pop_front());
                res_model = e;
            end else begin
                check("listo_idle", 64'(listo), 64'(0));
            end
            check("ocupado", 64'(ocupado), 64'(cyc_q.size() > 0));
            check("diferencia", 64'(diferencia), 64'(res_model[W-1:0]));
            check("desborde", 64'(desborde), 64'(res_model[W]));
            check("prestamo", 64'(prestamo_salida), 64'(res_model[W+1]));
        end
    end

    // ---------------- driver tasks ----------------
    // Assumes the design is idle (or in its listo cycle) at the next edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        A      = a;
        B      = b;
        inicio = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(a, b));
        cyc_q.push_back(cyc + W);
        inicio = 1'b0;
        A      = W'($urandom);
        B      = W'($urandom);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (cyc_q.size() > 0 && i < 100) begin
            @(posedge clk);
            #3;
            i++;
        end
        check("drain_timeout", 64'(cyc_q.size()), 64'(0));
    endtask

    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ed, input logic eb, input logic eo);
        start_op(a, b);
        wait_idle();
        check("dir_diferencia", 64'(diferencia), 64'(ed));
        check("dir_prestamo", 64'(prestamo_salida), 64'(eb));
        check("dir_desborde", 64'(desborde), 64'(eo));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ocupado"}, 64'(ocupado), 64'(0));
        check({tag, "_listo"}, 64'(listo), 64'(0));
        check({tag, "_diferencia"}, 64'(diferencia), 64'(0));
        check({tag, "_prestamo"}, 64'(prestamo_salida), 64'(0));
        check({tag, "_desborde"}, 64'(desborde), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n  = 1'b0;
        inicio = 1'b0;
        A      = '0;
        B      = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        directed(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        directed(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        directed(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        directed(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Back-to-back: second inicio lands in the listo cycle of the first.
        start_op(8'h00, 8'h00);
        repeat (W) @(negedge clk);
        start_op(8'hFF, 8'hFF);
        wait_idle();
        check("b2b_diferencia", 64'(diferencia), 64'(0));
        check("b2b_prestamo", 64'(prestamo_salida), 64'(0));
        check("b2b_desborde", 64'(desborde), 64'(0));

        // inicio during an operation must be ignored.
        start_op(8'h40, 8'h11);
        repeat (2) @(negedge clk);
        @(negedge clk);
        inicio = 1'b1;
        A      = 8'hAA;
        B      = 8'h55;
        @(negedge clk);
        inicio = 1'b0;
        wait_idle();
        check("ign_diferencia", 64'(diferencia), 64'(8'h2F));
        repeat (2 * W) @(posedge clk);

        // Asynchronous reset in the middle of an operation.
        start_op(8'h22, 8'h11);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        res_model = '0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * W) @(posedge clk);
        directed(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        // Randomized operations, some issued back-to-back.
        repeat (40) begin
            ra = W'($urandom);
            rb = W'($urandom);
            start_op(ra, rb);
            if ($urandom_range(0, 1) == 1) begin
                repeat (W) @(negedge clk);
            end else begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
